botones_antirrebote: RTL and testbench

Front-end conditioning stage for the minesweeper game FSM. Takes the four raw, active-low push-buttons from the board: down, right, bomba, bandera. For each one it synchronizes, debounces and one-shots the input, then arbitrates between them. The FSM receives at most one single-cycle, active-high action pulse per clock, so one press yields exactly one move, reveal or flag.

---
 rtl/botones_antirrebote_if.sv | 37 +++
 rtl/botones_antirrebote.sv | 86 ++++++++
 tb/tb_botones_antirrebote.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/botones_antirrebote_if.sv
// Button/action bundle between the board push-buttons and the game FSM front end.
// The master side drives the raw buttons; the slave (conditioning stage) returns pulses and held levels.
interface botones_antirrebote_if;
  logic       button_down;
  logic       button_right;
  logic       button_bomba;
  logic       button_bandera;
  logic       pulse_down;
  logic       pulse_right;
  logic       pulse_bomba;
  logic       pulse_bandera;
  logic [3:0] held;

  modport master (
    output button_down,
    output button_right,
    output button_bomba,
    output button_bandera,
    input  pulse_down,
    input  pulse_right,
    input  pulse_bomba,
    input  pulse_bandera,
    input  held
  );

  modport slave (
    input  button_down,
    input  button_right,
    input  button_bomba,
    input  button_bandera,
    output pulse_down,
    output pulse_right,
    output pulse_bomba,
    output pulse_bandera,
    output held
  );
endinterface

// File: rtl/botones_antirrebote.sv
// Synchronizes, debounces and one-shots four active-low buttons, then arbitrates so the
// game FSM sees at most one single-cycle action pulse per clock (down > right > bomba > bandera).
module botones_antirrebote #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  botones_antirrebote_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       accept;
  logic [3:0]       press_evt;
  logic [3:0]       pending;
  logic [3:0]       grant;
  logic [3:0]       pulse;

  // Channel index order {bandera, bomba, right, down} also fixes arbitration priority.
  assign raw = {bus.button_bandera, bus.button_bomba, bus.button_right, bus.button_down};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    accept    = '0;
    press_evt = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i]    = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
      press_evt[i] = accept[i] && stable[i];
    end
  end

  // Any edge where the synchronized level agrees with the accepted one restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= 4'hF;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Isolates the lowest set pending bit.
  assign grant = pending & (~pending + 4'd1);

  // A fresh press on a channel being served re-arms it, so set wins over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      pulse   <= '0;
    end else begin
      pulse   <= grant;
      pending <= (pending & ~grant) | press_evt;
    end
  end

  assign bus.pulse_down    = pulse[0];
  assign bus.pulse_right   = pulse[1];
  assign bus.pulse_bomba   = pulse[2];
  assign bus.pulse_bandera = pulse[3];
  assign bus.held          = ~stable;

endmodule

// File: tb/tb_botones_antirrebote.sv
// Randomized bench for botones_antirrebote with DEBOUNCE_CYCLES = 4, checked every cycle
// against a window-based reference model of debounce, press detection and priority service.
module tb_botones_antirrebote;
  localparam int D  = 4;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'hF;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  botones_antirrebote_if bif ();

  assign bif.button_down    = btn[0];
  assign bif.button_right   = btn[1];
  assign bif.button_bomba   = btn[2];
  assign bif.button_bandera = btn[3];

  botones_antirrebote #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  logic [3:0] dut_pulse;
  assign dut_pulse = {bif.pulse_bandera, bif.pulse_bomba, bif.pulse_right, bif.pulse_down};

  // Reference: two-sample delay line, then a level is accepted once the last D samples all differ.
  bit         dl  [4][$];
  bit         win [4][$];
  bit [3:0]   m_stable;
  logic [3:0] m_pending;
  logic [3:0] m_pulse;
  int         seen [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      dl[i].delete();
      dl[i].push_back(1'b1);
      dl[i].push_back(1'b1);
      win[i].delete();
    end
    m_stable  = 4'hF;
    m_pending = 4'h0;
    m_pulse   = 4'h0;
  endtask

  task automatic model_edge();
    logic [3:0] press;
    logic [3:0] serve;
    bit         d;
    bit         all_diff;
    press = 4'h0;
    serve = 4'h0;
    for (int i = 0; i < 4; i++) begin
      d = dl[i].pop_front();
      dl[i].push_back(btn[i]);
      win[i].push_back(d);
      if (win[i].size() > D) void'(win[i].pop_front());
      if (win[i].size() == D) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (win[i][k] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          if (m_stable[i]) press[i] = 1'b1;
          m_stable[i] = ~m_stable[i];
          win[i].delete();
        end
      end
    end
    for (int i = 0; i < 4; i++) if (m_pending[i] && serve == 4'h0) serve[i] = 1'b1;
    m_pulse   = serve;
    m_pending = (m_pending & ~serve) | press;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      passed++;
  endtask

  task automatic check_all();
    check_output("pulse", {28'h0, dut_pulse}, {28'h0, m_pulse});
    check_output("held", {28'h0, bif.held}, {28'h0, ~m_stable});
    check_output("onehot", $countones(dut_pulse) <= 1, 1);
    for (int i = 0; i < 4; i++) if (dut_pulse[i]) seen[i]++;
  endtask

  task automatic one_cycle();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all();
  endtask

  task automatic apply_stimulus(input logic [3:0] b, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      btn = b;
      one_cycle();
    end
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 4; i++) seen[i] = 0;
  endtask

  int seg_left [4];
  bit seg_lvl  [4];
  int rst_hold;

  initial begin
    model_reset();
    clear_seen();
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_pulse", {28'h0, dut_pulse}, 0);
    check_output("rst_held", {28'h0, bif.held}, 0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(4'hF, 6);
    check_output("idle_pulses", seen[0] + seen[1] + seen[2] + seen[3], 0);

    clear_seen();
    apply_stimulus(4'b1110, 20);
    apply_stimulus(4'hF, 12);
    check_output("down_once", seen[0], 1);

    clear_seen();
    for (int t = 0; t < 15; t++) apply_stimulus((t % 2 == 0) ? 4'b1011 : 4'hF, 2);
    apply_stimulus(4'hF, 10);
    check_output("bounce_none", seen[2], 0);
    apply_stimulus(4'b1011, 12);
    apply_stimulus(4'hF, 12);
    check_output("bomba_once", seen[2], 1);

    clear_seen();
    apply_stimulus(4'h0, 20);
    apply_stimulus(4'hF, 12);
    check_output("simul_count", seen[0] + seen[1] + seen[2] + seen[3], 4);

    clear_seen();
    apply_stimulus(4'b0111, 100);
    check_output("bandera_once", seen[3], 1);
    apply_stimulus(4'hF, 8);
    apply_stimulus(4'b0111, 12);
    check_output("bandera_rearm", seen[3], 2);
    apply_stimulus(4'hF, 10);

    // Random segments: short ones act as bounces, long ones as real presses/releases.
    for (int i = 0; i < 4; i++) begin
      seg_left[i] = 0;
      seg_lvl[i]  = 1'b1;
    end
    rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (seg_left[i] == 0) begin
          seg_lvl[i]  = $urandom_range(0, 1) == 1;
          seg_left[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 25);
        end
        btn[i] = seg_lvl[i];
        seg_left[i]--;
      end
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_output("rst_imm_pulse", {28'h0, dut_pulse}, 0);
        check_output("rst_imm_held", {28'h0, bif.held}, 0);
        rst_hold = $urandom_range(1, 3);
      end
      one_cycle();
    end

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
